mem_arb_2to1: RTL
=================

Name: mem_arb_2to1

Overview:
- Arbitrates one memory port between two MemIntf clients: port 0 is the SPI loader (SPI-to-memory write client), port 1 is the processor.
- Selects one request per cycle by round-robin, forwards it unchanged, and records the requester ID in an in-order route FIFO.
- Responses return in order and are steered back to the originating client, so both clients can issue requests without tag collisions.

Parameters:
- p_opaq_bits, 8: width of the opaque field; carried through unmodified.
- p_max_inflight, 4: route FIFO depth, i.e. the maximum outstanding requests; power of two, at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock, synchronous, active-high.
- cli0  MemIntf.server  -  SPI loader side; highest priority after reset.
- cli1  MemIntf.server  -  processor side.
- mem  MemIntf.client  -  shared downstream memory port.
- inflight  output  clog2(p_max_inflight)+1  count of outstanding requests.

Behaviour:
- Reset values:
  - inflight=0, route FIFO empty.
  - Round-robin pointer favours cli0.
  - mem.req_val=0, mem.resp_rdy=0, cli*.resp_val=0.
  - cli*.req_rdy=0 while the route FIFO is full, otherwise it follows the grant rule below.
- Grant (combinational):
  - Candidates are the clients with req_val=1.
  - If both are valid, grant the one favoured by the pointer. If only one is valid, grant it.
  - No grant when the FIFO is full.
- Request path:
  - mem.req_val = any grant.
  - mem.req_msg = granted client's req_msg, bit-exact (op, opaque, addr, strb, data).
  - cli[g].req_rdy = mem.req_rdy & !full. The non-granted client sees req_rdy=0.
- Accepted request (mem.req_val & mem.req_rdy):
  - Push grant ID g into the route FIFO.
  - Pointer moves to favour the other client on the next cycle.
  - The pointer does not change on cycles with no acceptance, so a stalled grant stays stable: no grant switching while mem.req_rdy=0 and the granted client holds val.
- Response path:
  - The FIFO head gives ID h.
  - cli[h].resp_val = mem.resp_val & !empty. The other client's resp_val=0.
  - cli[h].resp_msg = mem.resp_msg. Both clients receive mem.resp_msg, but only cli[h] has resp_val asserted.
  - mem.resp_rdy = cli[h].resp_rdy & !empty.
  - On mem.resp_val & mem.resp_rdy, pop the FIFO.
- Latency: zero added cycles on the request and response paths; purely combinational steering plus FIFO state.
- Full boundary:
  - full blocks a push even if a pop occurs in the same cycle.
  - This is deliberate: there is no comb path from resp handshake to req_rdy.
  - Push+pop in the same cycle when not full or empty: pointers advance together, inflight unchanged.
- Empty boundary: mem.resp_rdy=0. A response while empty is a protocol violation; a sim-only assertion fires and the message is not delivered.
- Same-cycle request and response for the same transaction is not supported: memory latency is at least 1 cycle.
- inflight = pushes - pops; it never exceeds p_max_inflight and never wraps. Internal FIFO pointers wrap modulo depth, with an extra bit for full/empty.
- Reset mid-operation: the FIFO is cleared and the pointer returns to cli0. The memory and clients are reset in the same cycle, so outstanding responses are discarded by design.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef mem_arb_id_t (1 bit).
  - localparams ARB_ID_SPI=0, ARB_ID_PROC=1.
- Sub-module mem_arb_route_fifo:
  - Parameterised depth, 1-bit data.
  - Ports push_en, push_data, pop_en, head, full, empty, count.
  - Synchronous active-high reset on rst.
- The top level holds the grant/pointer logic and the muxing.

Test Plan:
- Single client:
  - cli0 write addr 0x100 data 0xDEADBEEF, mem.req_rdy=1 → mem sees the identical msg the same cycle, inflight 0→1.
  - Response 2 cycles later reaches cli0 only; inflight returns to 0.
- Contention:
  - Both clients hold req_val every cycle, mem always ready → accepted IDs alternate 0,1,0,1 starting with 0 after reset.
  - Responses are routed in the same order.
- Stall stability: both valid, mem.req_rdy=0 for 5 cycles → grant and mem.req_msg stay on the same client throughout; accepted when req_rdy rises.
- Full:
  - 4 accepted requests with no responses → both req_rdy=0 and inflight=4.
  - Response delivered in a cycle with a pending request → pop occurs, no push that cycle; push occurs the next cycle.
- Response backpressure: head=cli1, cli1.resp_rdy=0 for 3 cycles → mem.resp_rdy=0, FIFO unchanged, cli0.resp_val=0; pops when cli1 is ready.
- Reset mid-flight: 3 outstanding, assert rst for 1 cycle → inflight=0, empty, next contention grant goes to cli0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: client ids and memory message field widths shared by
// the 2:1 memory arbiter, its route FIFO, the MemIntf bus and benches.
package mem_arb_pkg;

    typedef logic mem_arb_id_t;

    localparam mem_arb_id_t ARB_ID_SPI  = 1'b0;
    localparam mem_arb_id_t ARB_ID_PROC = 1'b1;

    localparam int MEM_OP_BITS   = 2;
    localparam int MEM_ADDR_BITS = 32;
    localparam int MEM_STRB_BITS = 4;
    localparam int MEM_DATA_BITS = 32;

    // Request message packs {op, opaque, addr, strb, data}, MSB first.
    function automatic int mem_req_bits(input int opaq_bits);
        return MEM_OP_BITS + opaq_bits + MEM_ADDR_BITS
             + MEM_STRB_BITS + MEM_DATA_BITS;
    endfunction

    // Response message packs {op, opaque, data}, MSB first.
    function automatic int mem_resp_bits(input int opaq_bits);
        return MEM_OP_BITS + opaq_bits + MEM_DATA_BITS;
    endfunction

endpackage

// File: rtl/mem_arb_2to1_if.sv
// MemIntf: valid/ready request and response channels of a memory port.
// client drives requests and accepts responses; server does the reverse.
interface MemIntf #(
    parameter int p_opaq_bits = 8
);
    import mem_arb_pkg::*;

    localparam int REQ_BITS  = mem_req_bits(p_opaq_bits);
    localparam int RESP_BITS = mem_resp_bits(p_opaq_bits);

    logic                 req_val;
    logic                 req_rdy;
    logic [REQ_BITS-1:0]  req_msg;
    logic                 resp_val;
    logic                 resp_rdy;
    logic [RESP_BITS-1:0] resp_msg;

    modport client (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport server (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );

endinterface

// File: rtl/mem_arb_route_fifo.sv
// mem_arb_route_fifo: in-order FIFO of 1-bit requester ids.
// Ports: clk, rst (sync, active-high), push_en/push_data, pop_en, head, full, empty, count.
module mem_arb_route_fifo
    import mem_arb_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_en,
    input  mem_arb_id_t                 push_data,
    input  logic                        pop_en,
    output mem_arb_id_t                 head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(p_depth):0]    count
);
    localparam int AW = $clog2(p_depth);

    mem_arb_id_t slots [p_depth];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW])
                && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = slots[rd_ptr[AW-1:0]];

    assign do_push = push_en & ~full;
    assign do_pop  = pop_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arb_2to1.sv
// mem_arb_2to1: round-robin 2:1 arbiter of one memory port; responses return in order to their requester.
// Ports: clk, rst (sync, active-high), cli0 (SPI loader), cli1 (processor), mem (downstream), inflight.
module mem_arb_2to1
    import mem_arb_pkg::*;
#(
    parameter int p_opaq_bits    = 8,
    parameter int p_max_inflight = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    MemIntf.server                            cli0,
    MemIntf.server                            cli1,
    MemIntf.client                            mem,
    output logic [$clog2(p_max_inflight):0]   inflight
);
    localparam int REQ_BITS = mem_req_bits(p_opaq_bits);

    mem_arb_id_t          favour;
    mem_arb_id_t          grant;
    mem_arb_id_t          head;
    logic                 grant_val;
    logic                 full;
    logic                 empty;
    logic                 accept;
    logic                 deliver;
    logic [REQ_BITS-1:0]  req_sel;

    // favour only breaks ties; a lone requester always wins.
    always_comb begin
        grant_val = 1'b0;
        grant     = favour;
        if (!full) begin
            grant_val = cli0.req_val | cli1.req_val;
            if (cli0.req_val && !cli1.req_val) begin
                grant = ARB_ID_SPI;
            end else if (cli1.req_val && !cli0.req_val) begin
                grant = ARB_ID_PROC;
            end
        end
    end

    assign req_sel = (grant == ARB_ID_PROC) ? cli1.req_msg : cli0.req_msg;

    assign mem.req_val = grant_val;
    assign mem.req_msg = req_sel;

    assign cli0.req_rdy = grant_val & (grant == ARB_ID_SPI)
                        & mem.req_rdy & ~full;
    assign cli1.req_rdy = grant_val & (grant == ARB_ID_PROC)
                        & mem.req_rdy & ~full;

    assign accept = grant_val & mem.req_rdy;

    // Holding favour while unaccepted keeps a stalled grant stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            favour <= ARB_ID_SPI;
        end else if (accept) begin
            favour <= ~grant;
        end
    end

    assign cli0.resp_msg = mem.resp_msg;
    assign cli1.resp_msg = mem.resp_msg;

    assign cli0.resp_val = mem.resp_val & ~empty & (head == ARB_ID_SPI);
    assign cli1.resp_val = mem.resp_val & ~empty & (head == ARB_ID_PROC);

    assign mem.resp_rdy = ~empty
                        & ((head == ARB_ID_PROC) ? cli1.resp_rdy : cli0.resp_rdy);

    assign deliver = mem.resp_val & mem.resp_rdy;

    mem_arb_route_fifo #(
        .p_depth (p_max_inflight)
    ) u_route (
        .clk       (clk),
        .rst       (rst),
        .push_en   (accept),
        .push_data (grant),
        .pop_en    (deliver),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (inflight)
    );

    // A response with nothing outstanding has no owner and is dropped.
    resp_when_empty: assert property (
        @(posedge clk) disable iff (rst) !(mem.resp_val && empty)
    );

endmodule
